// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and accumulator sizing for the convolution engine
package conv_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_e;

   // Wide enough for 2^addr_width full-scale products, so the sum cannot overflow.
   function automatic int acc_width(input int data_width, input int addr_width);
      return 2 * data_width + addr_width;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// rtl/conv_mac.sv - extend/multiply, accumulate and narrow one Z word
// CONV_SAT_EN: clamp the narrowed result to the active mode's range instead of wrapping.
module conv_mac
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode_signed,
   input  logic                  clr,
   input  logic                  en,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [OUT_WIDTH-1:0]  result,
   output logic                  sat
);

   localparam int ACC_W = acc_width(DATA_WIDTH, ADDR_WIDTH);
   localparam int PW    = 2 * DATA_WIDTH + 2;

   logic [PW-1:0]    a_e, b_e, prod;
   logic [ACC_W-1:0] acc_q, acc_d, acc_next;

   // Operands extended to the product width make one multiplier serve both modes.
   always_comb begin
      a_e      = {{(DATA_WIDTH + 2){mode_signed & a[DATA_WIDTH-1]}}, a};
      b_e      = {{(DATA_WIDTH + 2){mode_signed & b[DATA_WIDTH-1]}}, b};
      prod     = a_e * b_e;
      acc_next = en ? acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod} : acc_q;
      acc_d    = clr ? '0 : acc_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

`ifdef CONV_SAT_EN
   logic ovf_s, ovf_u;

   always_comb begin
      ovf_s  = acc_next[ACC_W-1:OUT_WIDTH-1] != {(ACC_W - OUT_WIDTH + 1){acc_next[ACC_W-1]}};
      ovf_u  = acc_next[ACC_W-1:OUT_WIDTH] != '0;
      result = acc_next[OUT_WIDTH-1:0];
      sat    = 1'b0;
      if (mode_signed && ovf_s) begin
         sat    = 1'b1;
         result = acc_next[ACC_W-1] ? {1'b1, {(OUT_WIDTH - 1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH - 1){1'b1}}};
      end else if (!mode_signed && ovf_u) begin
         sat    = 1'b1;
         result = '1;
      end
   end
`else
   assign result = acc_next[OUT_WIDTH-1:0];
   assign sat    = 1'b0;
`endif

endmodule

// File: rtl/conv_engine.sv
// rtl/conv_engine.sv - 1-D convolution engine: FSM, tap counters, bounds and memory addressing
// CONV_SAT_EN selects saturating narrowing inside conv_mac.
module conv_engine
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5,
   parameter int OUT_WIDTH  = 2 * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  mode_signed,
   input  logic [ADDR_WIDTH-1:0] sizeX,
   input  logic [ADDR_WIDTH-1:0] sizeY,
   input  logic [DATA_WIDTH-1:0] dataX,
   output logic [ADDR_WIDTH-1:0] memX_addr,
   input  logic [DATA_WIDTH-1:0] dataY,
   output logic [ADDR_WIDTH-1:0] memY_addr,
   output logic [OUT_WIDTH-1:0]  dataZ,
   output logic [ADDR_WIDTH:0]   memZ_addr,
   output logic                  writeZ,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  sat_out
);

   localparam int AW1 = ADDR_WIDTH + 1;
   localparam logic [AW1-1:0] ONE = AW1'(1);
   localparam logic [AW1-1:0] TWO = AW1'(2);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
   logic                  mode_q, mode_d;
   logic [AW1-1:0]        n_q, n_d, k_q, k_d, kmax_q, kmax_d, y_q, y_d;
   logic                  valid_q, valid_d;
   logic [OUT_WIDTH-1:0]  data_z_q, data_z_d;
   logic [AW1-1:0]        addr_z_q, addr_z_d;
   logic                  write_z_q, write_z_d;
   logic                  busy_q, busy_d, done_q, done_d, sat_q, sat_d;

   logic [AW1-1:0]        sx_e, sy_e, last_n, nn, kmin_nn, kmax_nn;
   logic                  load_bounds, mac_clr, mac_sat;
   logic [OUT_WIDTH-1:0]  mac_result;

   // Bounds are always evaluated for the n about to be processed: 0 from LOAD, n+1 from WRITE.
   always_comb begin
      sx_e    = {1'b0, sx_q};
      sy_e    = {1'b0, sy_q};
      last_n  = sx_e + sy_e - TWO;
      nn      = (state_q == LOAD) ? '0 : n_q + ONE;
      kmin_nn = (nn + ONE > sy_e) ? nn + ONE - sy_e : '0;
      kmax_nn = (nn < sx_e) ? nn : sx_e - ONE;
   end

   always_comb begin
      state_d     = state_q;
      sx_d        = sx_q;
      sy_d        = sy_q;
      mode_d      = mode_q;
      n_d         = n_q;
      k_d         = k_q;
      kmax_d      = kmax_q;
      y_d         = y_q;
      addr_z_d    = addr_z_q;
      data_z_d    = data_z_q;
      write_z_d   = 1'b0;
      sat_d       = sat_q;
      mac_clr     = 1'b0;
      load_bounds = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               sx_d    = sizeX;
               sy_d    = sizeY;
               mode_d  = mode_signed;
               sat_d   = 1'b0;
            end
         end
         LOAD: begin
            mac_clr = 1'b1;
            n_d     = '0;
            if (sx_q == '0 || sy_q == '0) begin
               state_d = DONE;
            end else begin
               load_bounds = 1'b1;
            end
         end
         RUN: begin
            if (k_q == kmax_q) begin
               state_d = DRAIN;
            end else begin
               k_d = k_q + ONE;
               y_d = y_q - ONE;
            end
         end
         DRAIN: begin
            // The last product lands this cycle, so the narrowed sum is final here.
            state_d   = WRITE;
            write_z_d = 1'b1;
            addr_z_d  = n_q;
            data_z_d  = mac_result;
            if (mac_sat) begin
               sat_d = 1'b1;
            end
         end
         WRITE: begin
            mac_clr = 1'b1;
            if (n_q == last_n) begin
               state_d = DONE;
            end else begin
               n_d         = nn;
               load_bounds = 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (load_bounds) begin
         state_d = RUN;
         k_d     = kmin_nn;
         kmax_d  = kmax_nn;
         y_d     = nn - kmin_nn;
      end
      valid_d = (state_q == RUN);
      busy_d  = (state_d == LOAD) || (state_d == RUN) || (state_d == DRAIN) || (state_d == WRITE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q   <= IDLE;
         sx_q      <= '0;
         sy_q      <= '0;
         mode_q    <= 1'b0;
         n_q       <= '0;
         k_q       <= '0;
         kmax_q    <= '0;
         y_q       <= '0;
         valid_q   <= 1'b0;
         data_z_q  <= '0;
         addr_z_q  <= '0;
         write_z_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         mode_q    <= mode_d;
         n_q       <= n_d;
         k_q       <= k_d;
         kmax_q    <= kmax_d;
         y_q       <= y_d;
         valid_q   <= valid_d;
         data_z_q  <= data_z_d;
         addr_z_q  <= addr_z_d;
         write_z_q <= write_z_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         sat_q     <= sat_d;
      end
   end

   conv_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
   ) u_mac (
      .clk         (clk),
      .rst         (rstn),
      .mode_signed (mode_q),
      .clr         (mac_clr),
      .en          (valid_q),
      .a           (dataX),
      .b           (dataY),
      .result      (mac_result),
      .sat         (mac_sat)
   );

   assign memX_addr = k_q[ADDR_WIDTH-1:0];
   assign memY_addr = y_q[ADDR_WIDTH-1:0];
   assign dataZ     = data_z_q;
   assign memZ_addr = addr_z_q;
   assign writeZ    = write_z_q;
   assign busy_out  = busy_q;
   assign done_out  = done_q;
   assign sat_out   = sat_q;

endmodule

// File: doc/conv_engine.md
# conv_engine

Parametrised 1-D linear convolution engine, successor to the single-width unsigned convolver. Reads X and Y from external synchronous-read memories and computes Z[n] = Σ X[k]·Y[n−k] for n = 0 … sizeX+sizeY−2. It streams one tap per cycle through a pipelined MAC and writes each Z word to the Z memory. It adds runtime signed/unsigned mode, a configurable output width, empty-operand handling, and optional saturation.

## Interface
- DATA_WIDTH, 8, width of X/Y samples
- ADDR_WIDTH, 5, width of X/Y addresses and sizes
- OUT_WIDTH, 2*DATA_WIDTH, width of Z words
- clk  in  1  clock, rising edge
- rstn  in  1  reset; synchronous, active-high (1 = reset)
- start  in  1  start request, sampled only in IDLE
- mode_signed  in  1  1 = two's-complement operands, 0 = unsigned; latched at start
- sizeX  in  ADDR_WIDTH  X length, latched at start
- sizeY  in  ADDR_WIDTH  Y length, latched at start
- dataX  in  DATA_WIDTH  X read data, valid 1 cycle after memX_addr
- memX_addr  out  ADDR_WIDTH  X read address
- dataY  in  DATA_WIDTH  Y read data, valid 1 cycle after memY_addr
- memY_addr  out  ADDR_WIDTH  Y read address
- dataZ  out  OUT_WIDTH  Z write data
- memZ_addr  out  ADDR_WIDTH+1  Z write address
- writeZ  out  1  Z write strobe, 1 cycle per output
- busy_out  out  1  high while computing
- done_out  out  1  1-cycle completion pulse
- sat_out  out  1  sticky saturation flag, cleared at start

## Operation
- Reset: all outputs 0; FSM to IDLE; accumulator, counters and latched sizes cleared. Reset mid-run aborts immediately, with no further writeZ.
- States:
  - IDLE: start=1 → LOAD.
  - LOAD: latch sizes and mode; set n=0. sizeX==0 or sizeY==0 → DONE with no writes. Else load kmin/kmax for n → RUN.
  - RUN: drive memX_addr=k, memY_addr=n−k; k++ each cycle; k==kmax → DRAIN.
  - DRAIN: last product accumulates.
  - WRITE: writeZ=1, memZ_addr=n, dataZ=result. If n==sizeX+sizeY−2 → DONE; else n++, reload bounds, clear accumulator → RUN.
  - DONE: done_out=1 → IDLE.
- Tap bounds: kmin = max(0, n−sizeY+1), kmax = min(n, sizeX−1). Computed in ADDR_WIDTH+1 bits; never negative.
- MAC: product 2*DATA_WIDTH bits, sign- or zero-extended per the latched mode. Accumulator ACC_W = 2*DATA_WIDTH+ADDR_WIDTH bits, so it never overflows internally.
- Result: accumulator narrowed to OUT_WIDTH (see Configuration).
- start while busy: ignored. Size/mode input changes mid-run: ignored.
- busy_out is high in LOAD/RUN/DRAIN/WRITE and low in DONE and IDLE.

## Timing
- Memory read latency is exactly 1 cycle; products are registered in the cycle after address issue.
- Cycles per output n: taps(n)+2. Total busy cycles = 1 + sizeX·sizeY + 2·(sizeX+sizeY−1).
- Empty operand: busy for 1 cycle (LOAD), then done_out.
- done_out comes 1 cycle after the final writeZ. A new start is accepted the cycle after done_out.
- dataZ and memZ_addr hold their last values outside WRITE.

## Configuration
- CONV_SAT_EN defined: result clamps to the OUT_WIDTH range of the active mode. Signed range is [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]; unsigned range is [0, 2^OUT_WIDTH−1]. Any clamp sets sat_out until the next start.
- CONV_SAT_EN undefined: result is the low OUT_WIDTH bits (wrap); sat_out is tied 0.

## Structure
- Package conv_pkg: state enum (IDLE, LOAD, RUN, DRAIN, WRITE, DONE) and ACC_W derivation function.
- Sub-module conv_mac holds the extend/multiply, the accumulator with clear/enable, and the narrowing/saturation logic.
- The top level holds the FSM, n/k counters, bounds logic and address registers.

## Test plan
- Unsigned, X={1,2,3}, Y={4,5} → writes Z[0..3]={4,13,22,15} at addresses 0..3. busy_out high for 15 cycles, then one done_out pulse.
- Signed, X={0xFF,0x02}, Y={0x03}, OUT_WIDTH=16 → Z={0xFFFD,0x0006}. Same data unsigned → Z={0x02FD,0x0006}.
- sizeX=0, sizeY=4, start → no writeZ, busy_out for 1 cycle, done_out next cycle.
- Unsigned, X={255,255}, Y={255,255}, OUT_WIDTH=16 → Z[1]=0xFFFF and sat_out=1 with CONV_SAT_EN; Z[1]=0xFC02 and sat_out=0 without it.
- Assert rstn during RUN of a 4×4 job → next cycle: all outputs 0, no writeZ; a fresh start then completes correctly.
- Pulse start during RUN and change sizeX mid-run → results unchanged, exactly sizeX+sizeY−1 writes.
